multicycle_control: RTL and testbench
=====================================

# multicycle_control

Sequencing controller for the multicycle MIPS datapath. It replaces the single-cycle combinational `main_control` with a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback states. It drives the shared-memory, register-bank, ALU-source and PC-source controls, and waits on a memory ready handshake. It also keeps a retired-instruction counter and a sticky halt on illegal encodings.

## Interface
- `CNT_W`, default 32: width of `instr_count`.
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset; highest priority.
- `opcode` in 6: instruction[31:26] from the instruction register.
- `func` in 6: instruction[5:0].
- `zero` in 1: ALU zero flag. Reserved, not used internally; branch gating is done in the datapath.
- `mem_ready` in 1: shared memory has completed the current read or write.
- `pc_write`, `pc_write_cond`, `ir_write`, `i_or_d`, `mem_read`, `mem_write`, `regwrite`, `regdst`, `mem2reg`, `extop`, `alusrc_a` out 1 each: datapath controls.
- `alusrc_b` out 2: 00 = reg B, 01 = constant 4, 10 = ext imm, 11 = ext imm<<2.
- `pc_source` out 2: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `aluop` out 4: ADD 0010, SUB 0110, AND 0000, OR 0001, SLT 0111.
- `state` out 4: current state, for debug.
- `halted` out 1: set in TRAP.
- `instr_count` out CNT_W: retired-instruction count.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, TRAP 12.
- Outputs are decoded from the state register. Any output not listed for a state is 0.
  - FETCH: mem_read=1, alusrc_b=01, aluop=ADD; ir_write and pc_write follow mem_ready (the only Mealy term).
  - DECODE: alusrc_b=11, aluop=ADD, extop=1. Latches opcode and func internally.
  - MEM_ADDR: alusrc_a=1, alusrc_b=10, aluop=ADD, extop=1.
  - MEM_READ: mem_read=1, i_or_d=1.
  - MEM_WB: regwrite=1, mem2reg=1, regdst=0.
  - MEM_WRITE: mem_write=1, i_or_d=1.
  - R_EXEC: alusrc_a=1, alusrc_b=00, aluop from latched func: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
  - R_WB: regwrite=1, regdst=1.
  - BRANCH: alusrc_a=1, aluop=SUB, pc_write_cond=1, pc_source=01.
  - JUMP: pc_write=1, pc_source=10.
  - I_EXEC: alusrc_a=1, alusrc_b=10. addi 0x08 gives ADD with extop=1; andi 0x0C gives AND with extop=0; ori 0x0D gives OR with extop=0.
  - I_WB: regwrite=1, regdst=0.
  - TRAP: halted=1, all other outputs 0.
- Transitions:
  - FETCH goes to DECODE only when mem_ready=1; otherwise it holds.
  - DECODE dispatches on opcode: 0x00 to R_EXEC, 0x23 (lw) or 0x2B (sw) to MEM_ADDR, 0x04 to BRANCH, 0x02 to JUMP, 0x08/0x0C/0x0D to I_EXEC, anything else to TRAP.
  - MEM_ADDR goes to MEM_READ for lw and MEM_WRITE for sw.
  - MEM_READ goes to MEM_WB on mem_ready. MEM_WRITE goes to FETCH on mem_ready. Both hold while mem_ready=0.
  - MEM_WB, R_WB, I_WB, BRANCH and JUMP go to FETCH. R_EXEC goes to R_WB; I_EXEC goes to I_WB.
  - An R-type with an unknown func goes from R_EXEC to TRAP.
  - TRAP is absorbing until rst.
- instr_count:
  - Increments by 1 on the edge that leaves MEM_WB, R_WB, I_WB, BRANCH or JUMP, and on the edge that leaves MEM_WRITE with mem_ready=1.
  - Wraps from all-ones to 0.
- mem_ready is ignored in every state except FETCH, MEM_READ and MEM_WRITE.

## Timing
- Reset values, effective the cycle after the rst edge:
  - state = FETCH, instr_count = 0, halted = 0, latched opcode/func = 0.
  - Outputs take FETCH values: mem_read=1, alusrc_b=01, aluop=0010, pc_write = ir_write = mem_ready, all others 0.
- Latency with zero wait states: beq and j take 3 cycles; R-type, addi/andi/ori and sw take 4; lw takes 5. Each cycle with mem_ready low in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- rst asserted in any state, including mid-MEM_WRITE with mem_ready=0 and in TRAP, returns to FETCH on that edge. The write is abandoned and mem_write is 0 from the next cycle. No count increment occurs on a reset edge.
- rst and a retiring edge in the same cycle: reset wins and the count becomes 0.

## Structure
- Package `mc_pkg` holds: state constants, opcode and func constants, ALU op codes, and the alusrc_b and pc_source encodings.
- One combinational sub-module `alu_decode` maps (state, latched opcode, latched func) to {aluop, extop, func_illegal}.
- The FSM, output decode and counter live in `multicycle_control`.

## Test plan
- Reset: hold rst=1 for 2 cycles with mem_ready=1. Expect state=0, mem_read=1, pc_write=1, ir_write=1, instr_count=0, halted=0.
- add: opcode 0x00, func 0x20, mem_ready=1. Expect states 0,1,6,7,0; in R_EXEC aluop=0010 with alusrc_a=1 and alusrc_b=00; in R_WB regwrite=1 and regdst=1; instr_count goes 0 to 1.
- lw with mem_ready=0 for 3 cycles in MEM_READ. Expect MEM_READ held 4 cycles with mem_read=1 and i_or_d=1; regwrite=1 only in MEM_WB with mem2reg=1; 8 cycles in total.
- beq, opcode 0x04. Expect BRANCH on cycle 3 with pc_write_cond=1, pc_source=01, aluop=0110; back to FETCH next cycle; count +1.
- Illegal opcode 0x3F, then R-type func 0x3F after reset. Both reach TRAP (at cycle 3 and cycle 4 respectively). Expect halted=1, all controls 0, TRAP held for 20 cycles; rst returns to FETCH.
- With CNT_W=4, issue 16 j instructions. Expect instr_count 15 to 0 on the 16th. Then assert rst during MEM_WRITE with mem_ready=0: mem_write=0 next cycle and instr_count=0.

Source files
------------

// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared constants for the multicycle MIPS sequencing controller:
//   - FSM state encodings (also visible on the debug 'state' port)
//   - opcode and R-type func field values
//   - ALU operation codes driven on 'aluop'
//   - alusrc_b and pc_source mux select encodings
//   - helper functions for opcode dispatch and retirement detection
// ---------------------------------------------------------------------------
package mc_pkg;

    // FSM states
    localparam logic [3:0] ST_FETCH     = 4'd0;
    localparam logic [3:0] ST_DECODE    = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
    localparam logic [3:0] ST_MEM_READ  = 4'd3;
    localparam logic [3:0] ST_MEM_WB    = 4'd4;
    localparam logic [3:0] ST_MEM_WRITE = 4'd5;
    localparam logic [3:0] ST_R_EXEC    = 4'd6;
    localparam logic [3:0] ST_R_WB      = 4'd7;
    localparam logic [3:0] ST_BRANCH    = 4'd8;
    localparam logic [3:0] ST_JUMP      = 4'd9;
    localparam logic [3:0] ST_I_EXEC    = 4'd10;
    localparam logic [3:0] ST_I_WB      = 4'd11;
    localparam logic [3:0] ST_TRAP      = 4'd12;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type func codes (instruction[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // ALU B-operand select
    localparam logic [1:0] ASB_REG    = 2'b00;
    localparam logic [1:0] ASB_FOUR   = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // First execute-phase state for a freshly decoded opcode; unknown
    // encodings go straight to the absorbing TRAP state.
    function automatic logic [3:0] dispatch_state(input logic [5:0] op);
        logic [3:0] st;
        case (op)
            OP_RTYPE:               st = ST_R_EXEC;
            OP_LW, OP_SW:           st = ST_MEM_ADDR;
            OP_BEQ:                 st = ST_BRANCH;
            OP_J:                   st = ST_JUMP;
            OP_ADDI, OP_ANDI,
            OP_ORI:                 st = ST_I_EXEC;
            default:                st = ST_TRAP;
        endcase
        return st;
    endfunction

    // States whose exit unconditionally completes an instruction.
    // MEM_WRITE also retires, but only when memory accepts the write.
    function automatic logic is_final_state(input logic [3:0] st);
        logic fin;
        case (st)
            ST_MEM_WB, ST_R_WB, ST_I_WB,
            ST_BRANCH, ST_JUMP:     fin = 1'b1;
            default:                fin = 1'b0;
        endcase
        return fin;
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decode.sv
// ---------------------------------------------------------------------------
// alu_decode
// Combinational ALU control decode for the multicycle controller.
// Ports:
//   state        in  4 : current FSM state
//   opcode       in  6 : opcode latched in DECODE
//   func         in  6 : func field latched in DECODE
//   aluop        out 4 : ALU operation for this state
//   extop        out 1 : 1 = sign-extend immediate, 0 = zero-extend
//   func_illegal out 1 : R_EXEC with an unsupported func field
// ---------------------------------------------------------------------------
module alu_decode
    import mc_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output logic [3:0] aluop,
    output logic       extop,
    output logic       func_illegal
);

    // ALU operation / extension select per state
    always_comb begin
        aluop        = ALU_AND;
        extop        = 1'b0;
        func_illegal = 1'b0;
        case (state)
            // PC + 4
            ST_FETCH: begin
                aluop = ALU_ADD;
            end
            // Speculative branch target PC + (imm << 2), sign-extended
            ST_DECODE: begin
                aluop = ALU_ADD;
                extop = 1'b1;
            end
            // Effective address base + sign-extended offset
            ST_MEM_ADDR: begin
                aluop = ALU_ADD;
                extop = 1'b1;
            end
            ST_R_EXEC: begin
                case (func)
                    FN_ADD:  aluop = ALU_ADD;
                    FN_SUB:  aluop = ALU_SUB;
                    FN_AND:  aluop = ALU_AND;
                    FN_OR:   aluop = ALU_OR;
                    FN_SLT:  aluop = ALU_SLT;
                    default: func_illegal = 1'b1;
                endcase
            end
            // Compare by subtraction; datapath gates pc_write_cond with zero
            ST_BRANCH: begin
                aluop = ALU_SUB;
            end
            // Logical immediates are zero-extended, addi is sign-extended
            ST_I_EXEC: begin
                case (opcode)
                    OP_ADDI: begin
                        aluop = ALU_ADD;
                        extop = 1'b1;
                    end
                    OP_ANDI: aluop = ALU_AND;
                    OP_ORI:  aluop = ALU_OR;
                    default: aluop = ALU_AND;
                endcase
            end
            default: begin
                aluop = ALU_AND;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore sequencing FSM for the multicycle MIPS datapath. Steps each
// instruction through fetch / decode / execute / memory / writeback,
// waits on the shared-memory ready handshake, counts retired instructions
// and halts permanently (until rst) on illegal encodings.
// Ports:
//   clk, rst (sync, active-high)
//   opcode[5:0], func[5:0] : instruction fields from the instruction register
//   zero                   : ALU zero flag (branch gating lives in the datapath)
//   mem_ready              : shared memory finished current read/write
//   pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
//   regwrite, regdst, mem2reg, extop, alusrc_a : datapath controls
//   alusrc_b[1:0], pc_source[1:0], aluop[3:0]  : mux / ALU selects
//   state[3:0]             : current state (debug)
//   halted                 : in TRAP
//   instr_count[CNT_W-1:0] : retired-instruction count, wraps
// ---------------------------------------------------------------------------
module multicycle_control
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             regwrite,
    output logic             regdst,
    output logic             mem2reg,
    output logic             extop,
    output logic             alusrc_a,
    output logic [1:0]       alusrc_b,
    output logic [1:0]       pc_source,
    output logic [3:0]       aluop,
    output logic [3:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    logic [3:0]       state_r;
    logic [3:0]       next_state_s;
    logic [5:0]       opcode_r;
    logic [5:0]       func_r;
    logic [CNT_W-1:0] instr_count_r;
    logic             retire_s;
    logic [3:0]       aluop_s;
    logic             extop_s;
    logic             func_illegal_s;
    logic             zero_unused_s;

    // Branch resolution is done in the datapath; the flag is reserved here.
    assign zero_unused_s = zero;

    assign state       = state_r;
    assign instr_count = instr_count_r;

    alu_decode u_alu_decode (
        .state        (state_r),
        .opcode       (opcode_r),
        .func         (func_r),
        .aluop        (aluop_s),
        .extop        (extop_s),
        .func_illegal (func_illegal_s)
    );

    // Next-state selection
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (mem_ready) begin
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            // IR is valid here, so dispatch uses the live opcode
            ST_DECODE: begin
                next_state_s = dispatch_state(opcode);
            end
            // Only lw and sw reach MEM_ADDR
            ST_MEM_ADDR: begin
                if (opcode_r == OP_SW) begin
                    next_state_s = ST_MEM_WRITE;
                end else begin
                    next_state_s = ST_MEM_READ;
                end
            end
            ST_MEM_READ: begin
                if (mem_ready) begin
                    next_state_s = ST_MEM_WB;
                end else begin
                    next_state_s = ST_MEM_READ;
                end
            end
            ST_MEM_WRITE: begin
                if (mem_ready) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_MEM_WRITE;
                end
            end
            ST_R_EXEC: begin
                if (func_illegal_s) begin
                    next_state_s = ST_TRAP;
                end else begin
                    next_state_s = ST_R_WB;
                end
            end
            ST_I_EXEC: begin
                next_state_s = ST_I_WB;
            end
            ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: begin
                next_state_s = ST_FETCH;
            end
            ST_TRAP: begin
                next_state_s = ST_TRAP;
            end
            // Unused encodings are treated as corruption and halt the core
            default: begin
                next_state_s = ST_TRAP;
            end
        endcase
    end

    // Retirement strobe: high on the cycle whose exit completes an instruction
    always_comb begin
        if (state_r == ST_MEM_WRITE) begin
            retire_s = mem_ready;
        end else begin
            retire_s = is_final_state(state_r);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Opcode/func capture so later states are immune to IR changes
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_r <= 6'h00;
            func_r   <= 6'h00;
        end else if (state_r == ST_DECODE) begin
            opcode_r <= opcode;
            func_r   <= func;
        end else begin
            opcode_r <= opcode_r;
            func_r   <= func_r;
        end
    end

    // Retired-instruction counter; wraps naturally at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            instr_count_r <= instr_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instr_count_r <= instr_count_r;
        end
    end

    // Datapath control decode from the state register
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        regwrite      = 1'b0;
        regdst        = 1'b0;
        mem2reg       = 1'b0;
        alusrc_a      = 1'b0;
        alusrc_b      = ASB_REG;
        pc_source     = PCS_ALU;
        halted        = 1'b0;
        aluop         = aluop_s;
        extop         = extop_s;
        case (state_r)
            // IR load and PC+4 commit only once the fetch read completes
            ST_FETCH: begin
                mem_read = 1'b1;
                alusrc_b = ASB_FOUR;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            ST_DECODE: begin
                alusrc_b = ASB_IMM_SH;
            end
            ST_MEM_ADDR: begin
                alusrc_a = 1'b1;
                alusrc_b = ASB_IMM;
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                regwrite = 1'b1;
                mem2reg  = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            ST_R_EXEC: begin
                alusrc_a = 1'b1;
                alusrc_b = ASB_REG;
            end
            ST_R_WB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            ST_BRANCH: begin
                alusrc_a      = 1'b1;
                pc_write_cond = 1'b1;
                pc_source     = PCS_ALUOUT;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCS_JUMP;
            end
            ST_I_EXEC: begin
                alusrc_a = 1'b1;
                alusrc_b = ASB_IMM;
            end
            ST_I_WB: begin
                regwrite = 1'b1;
            end
            ST_TRAP: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
// Drives directed and randomized instruction streams into the controller.
// For each instruction the bench plans the expected sequence of states from
// the instruction class and the chosen memory wait counts, then checks the
// state, every control output and the retired count on each cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    opcode = 6'h00;
    logic [5:0]    func = 6'h00;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b1;
    logic          pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic          regwrite, regdst, mem2reg, extop, alusrc_a, halted;
    logic [1:0]    alusrc_b, pc_source;
    logic [3:0]    aluop, state;
    logic [CW-1:0] instr_count;

    int n_cmp = 0;
    int n_err = 0;
    int model_cnt = 0;

    typedef struct packed {
        logic       pcw, pcwc, irw, iord, mrd, mwr, rw, rdst, m2r, ext, asa;
        logic [1:0] asb;
        logic [1:0] pcs;
        logic [3:0] aop;
        logic       hlt;
    } ctl_t;

    typedef struct {
        int st;
        int mr;   // mem_ready to drive; -1 = don't care (randomized)
    } ph_t;

    ph_t  plan[$];
    ctl_t obs_ctl;

    assign obs_ctl = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                      regwrite, regdst, mem2reg, extop, alusrc_a, alusrc_b, pc_source,
                      aluop, halted};

    multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .regwrite(regwrite), .regdst(regdst),
        .mem2reg(mem2reg), .extop(extop), .alusrc_a(alusrc_a),
        .alusrc_b(alusrc_b), .pc_source(pc_source), .aluop(aluop),
        .state(state), .halted(halted), .instr_count(instr_count)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit legal_func(input logic [5:0] fn);
        return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) || (fn == 6'h2A);
    endfunction

    function automatic logic [3:0] alu_of_func(input logic [5:0] fn);
        case (fn)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h2A:   return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    // Control values a given state must show
    function automatic ctl_t exp_ctl(input int st, input logic [5:0] op, input logic [5:0] fn,
                                     input logic mr);
        ctl_t c;
        c = '0;
        case (st)
            0:  begin c.mrd = 1'b1; c.asb = 2'b01; c.aop = 4'b0010; c.irw = mr; c.pcw = mr; end
            1:  begin c.asb = 2'b11; c.aop = 4'b0010; c.ext = 1'b1; end
            2:  begin c.asa = 1'b1; c.asb = 2'b10; c.aop = 4'b0010; c.ext = 1'b1; end
            3:  begin c.mrd = 1'b1; c.iord = 1'b1; end
            4:  begin c.rw = 1'b1; c.m2r = 1'b1; end
            5:  begin c.mwr = 1'b1; c.iord = 1'b1; end
            6:  begin c.asa = 1'b1; c.asb = 2'b00; c.aop = alu_of_func(fn); end
            7:  begin c.rw = 1'b1; c.rdst = 1'b1; end
            8:  begin c.asa = 1'b1; c.aop = 4'b0110; c.pcwc = 1'b1; c.pcs = 2'b01; end
            9:  begin c.pcw = 1'b1; c.pcs = 2'b10; end
            10: begin
                c.asa = 1'b1;
                c.asb = 2'b10;
                case (op)
                    6'h08:   begin c.aop = 4'b0010; c.ext = 1'b1; end
                    6'h0C:   c.aop = 4'b0000;
                    6'h0D:   c.aop = 4'b0001;
                    default: c.aop = 4'b0000;
                endcase
            end
            11: c.rw = 1'b1;
            12: c.hlt = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic check_cycle(input int st, input logic [5:0] op, input logic [5:0] fn);
        ctl_t        e;
        logic [19:0] mask;
        e    = exp_ctl(st, op, fn, mem_ready);
        // aluop for an unsupported func is left undefined; skip it there
        mask = (st == 6 && !legal_func(fn)) ? 20'hFFFE1 : 20'hFFFFF;
        check_eq("state", 32'(state), 32'(st));
        check_eq("ctl", 32'(obs_ctl & mask), 32'(e & mask));
        check_eq("count", 32'(instr_count), 32'(model_cnt % (1 << CW)));
    endtask

    // First cycle after rst drops: FETCH with memory not ready
    task automatic post_reset();
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b0;
        model_cnt = 0;
        #1 check_cycle(0, 6'h00, 6'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        model_cnt = 0;
        #1 check_cycle(0, 6'h00, 6'h00);
        post_reset();
    endtask

    // Plan and check one instruction; abort_st >= 0 asserts rst on the first
    // cycle spent in that state.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf,
                             input int wm, input int abort_st);
        bit trap;
        bit aborted;
        trap    = 1'b0;
        aborted = 1'b0;
        plan.delete();
        for (int i = 0; i < wf; i++) plan.push_back('{st: 0, mr: 0});
        plan.push_back('{st: 0, mr: 1});
        plan.push_back('{st: 1, mr: -1});
        case (op)
            6'h00: begin
                plan.push_back('{st: 6, mr: -1});
                if (legal_func(fn)) begin
                    plan.push_back('{st: 7, mr: -1});
                end else begin
                    plan.push_back('{st: 12, mr: -1});
                    trap = 1'b1;
                end
            end
            6'h23: begin
                plan.push_back('{st: 2, mr: -1});
                for (int i = 0; i < wm; i++) plan.push_back('{st: 3, mr: 0});
                plan.push_back('{st: 3, mr: 1});
                plan.push_back('{st: 4, mr: -1});
            end
            6'h2B: begin
                plan.push_back('{st: 2, mr: -1});
                for (int i = 0; i < wm; i++) plan.push_back('{st: 5, mr: 0});
                plan.push_back('{st: 5, mr: 1});
            end
            6'h04: plan.push_back('{st: 8, mr: -1});
            6'h02: plan.push_back('{st: 9, mr: -1});
            6'h08, 6'h0C, 6'h0D: begin
                plan.push_back('{st: 10, mr: -1});
                plan.push_back('{st: 11, mr: -1});
            end
            default: begin
                plan.push_back('{st: 12, mr: -1});
                trap = 1'b1;
            end
        endcase
        if (trap) begin
            for (int i = 0; i < 19; i++) plan.push_back('{st: 12, mr: -1});
        end
        foreach (plan[i]) begin
            @(negedge clk);
            mem_ready = (plan[i].mr < 0) ? 1'($urandom_range(0, 1)) : 1'(plan[i].mr);
            zero      = 1'($urandom_range(0, 1));
            if (plan[i].st == 1) begin
                opcode = op;
                func   = fn;
            end else begin
                opcode = 6'($urandom);
                func   = 6'($urandom);
            end
            rst = (plan[i].st == abort_st) ? 1'b1 : 1'b0;
            #1 check_cycle(plan[i].st, op, fn);
            if (rst) begin
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            post_reset();
        end else if (trap) begin
            do_reset();
        end else begin
            model_cnt++;
        end
    endtask

    initial begin
        logic [5:0] legal_ops[8];
        logic [5:0] legal_fns[5];
        logic [5:0] op;
        logic [5:0] fn;
        int         ab;
        legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h0C, 6'h0D};
        legal_fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        // Reset with memory ready, then directed cases
        do_reset();
        run_instr(6'h00, 6'h20, 0, 0, -1);   // add
        run_instr(6'h23, 6'h00, 0, 3, -1);   // lw, 3 wait states
        run_instr(6'h04, 6'h00, 0, 0, -1);   // beq
        run_instr(6'h2B, 6'h00, 1, 1, -1);   // sw with fetch and write waits
        run_instr(6'h08, 6'h00, 0, 0, -1);   // addi
        run_instr(6'h0C, 6'h00, 0, 0, -1);   // andi
        run_instr(6'h0D, 6'h00, 0, 0, -1);   // ori
        run_instr(6'h00, 6'h2A, 2, 0, -1);   // slt
        run_instr(6'h3F, 6'h00, 0, 0, -1);   // illegal opcode -> TRAP, reset
        run_instr(6'h00, 6'h3F, 0, 0, -1);   // illegal func -> TRAP, reset

        // Counter wrap: 16 jumps take a 4-bit count from 0 back to 0
        do_reset();
        for (int i = 0; i < 16; i++) run_instr(6'h02, 6'h00, 0, 0, -1);
        for (int i = 0; i < 3; i++) run_instr(6'h02, 6'h00, 0, 0, -1);
        run_instr(6'h2B, 6'h00, 0, 2, 5);    // reset mid-write with mem_ready=0
        run_instr(6'h04, 6'h00, 0, 0, -1);
        run_instr(6'h00, 6'h24, 0, 0, 7);    // reset on a retiring edge
        run_instr(6'h00, 6'h3F, 0, 0, 12);   // reset while in TRAP

        // Randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom);
            end else begin
                op = legal_ops[$urandom_range(0, 7)];
            end
            if ($urandom_range(0, 7) == 0) begin
                fn = 6'($urandom);
            end else begin
                fn = legal_fns[$urandom_range(0, 4)];
            end
            ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 12)) : -1;
            run_instr(op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), ab);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
